gobang_move_ctrl: RTL and testbench

Turn-based move controller for the 16x16 game-board memory. Arbitrates move requests from player 0 (black) and player 1 (white) and checks the target cell is empty against the board bus. Issues a single-cycle write into the board write port, then handshakes the result back to the requester. Also sequences a full-board clear; sits between the input/AI front ends and the board memory.

---
 rtl/gobang_move_ctrl_if.sv | 42 ++++
 rtl/gobang_move_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_gobang_move_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gobang_move_ctrl_if.sv
// gobang_move_ctrl_if
//
// Bundles the move-request handshake and the board-memory bus of the
// gobang move controller.
//   master : requester/environment side. It drives the requests, the clear
//            and the board contents, and observes the controller outputs.
//   slave  : controller side (gobang_move_ctrl).
// Signals:
//   req[1:0], req_xy0[7:0], req_xy1[7:0]   per-player move requests ([7:4]=x, [3:0]=y)
//   clear                                  board clear request
//   board[511:0]                           board contents, cell (x,y) at bits {x,y,1'b0} +: 2
//   mem_select, mem_data, mem_we           board write port
//   mem_rst_n                              active-low clear pulse to the board memory
//   ack, accepted                          per-player completion pulse and its result
//   turn, busy, move_count                 game status
`timescale 1ns/1ps
interface gobang_move_ctrl_if;
  logic [1:0]   req;
  logic [7:0]   req_xy0;
  logic [7:0]   req_xy1;
  logic         clear;
  logic [511:0] board;
  logic [7:0]   mem_select;
  logic [1:0]   mem_data;
  logic         mem_we;
  logic         mem_rst_n;
  logic [1:0]   ack;
  logic         accepted;
  logic         turn;
  logic         busy;
  logic [8:0]   move_count;

  modport master (
    output req, req_xy0, req_xy1, clear, board,
    input  mem_select, mem_data, mem_we, mem_rst_n, ack, accepted, turn, busy, move_count
  );

  modport slave (
    input  req, req_xy0, req_xy1, clear, board,
    output mem_select, mem_data, mem_we, mem_rst_n, ack, accepted, turn, busy, move_count
  );
endinterface

// File: rtl/gobang_move_ctrl.sv
// gobang_move_ctrl
//
// Turn-based move controller for a 16x16 board of 2-bit cells
// (00 empty, 01 player 0, 10 player 1). It takes the move of the player on
// turn, checks that the target cell is empty, writes the stone with a
// single-cycle write, then pulses ack to the requester. It also runs a
// full-board clear.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    gobang_move_ctrl_if.slave (requests, board read bus, board write
//          port, ack/accepted, turn, busy, move_count)
//
// Build option:
//   GOBANG_CLEAR_SWEEP_EN  defined   : CLEAR writes 00 to addresses 0x00..0xFF,
//                                      one per cycle (256 mem_we cycles).
//                          undefined : CLEAR pulses mem_rst_n low for one cycle.
//
// Every output comes straight from a register.
`timescale 1ns/1ps
module gobang_move_ctrl (
  input  logic              clock,
  input  logic              reset,
  gobang_move_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] CLEAR = 3'd4;

  // Extracts the 2-bit cell addressed by xy ({x,y}) from the flat board vector.
  function automatic logic [1:0] cell_at(input logic [511:0] b, input logic [7:0] xy);
    cell_at = b[{xy, 1'b0} +: 2];
  endfunction

  // One-hot ack pattern for a player id.
  function automatic logic [1:0] player_onehot(input logic p);
    player_onehot = p ? 2'b10 : 2'b01;
  endfunction

  logic [2:0] state_r;
  logic [2:0] state_nx_s;
  logic       turn_r;
  logic [1:0] armed_r;
  logic       player_r;
  logic [7:0] xy_r;
  logic       accepted_r;
  logic [1:0] ack_r;
  logic [7:0] mem_select_r;
  logic [1:0] mem_data_r;
  logic       mem_we_r;
  logic       mem_rst_n_r;
  logic       busy_r;
  logic [8:0] move_count_r;
  // Marks the final CLEAR cycle, in which the game state is re-initialised.
  logic       clear_end_r;
`ifdef GOBANG_CLEAR_SWEEP_EN
  logic [8:0] sweep_cnt_r;
`endif

  logic       start_move_s;
  logic       cell_empty_s;

  // Only the player on turn can start a move, and only once per req assertion.
  assign start_move_s = bus.req[turn_r] & armed_r[turn_r];
  assign cell_empty_s = (cell_at(bus.board, xy_r) == 2'b00);

  // Next-state selection for the move/clear sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.clear) begin
          state_nx_s = CLEAR;
        end else if (start_move_s) begin
          state_nx_s = CHECK;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CHECK: begin
        if (cell_empty_s) begin
          state_nx_s = WRITE;
        end else begin
          state_nx_s = ACK;
        end
      end
      WRITE: state_nx_s = ACK;
      ACK:   state_nx_s = IDLE;
      CLEAR: begin
        if (clear_end_r) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLEAR;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Sequencer registers and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      turn_r       <= 1'b0;
      armed_r      <= 2'b11;
      player_r     <= 1'b0;
      xy_r         <= 8'h00;
      accepted_r   <= 1'b0;
      ack_r        <= 2'b00;
      mem_select_r <= 8'h00;
      mem_data_r   <= 2'b00;
      mem_we_r     <= 1'b0;
      mem_rst_n_r  <= 1'b1;
      busy_r       <= 1'b0;
      move_count_r <= 9'd0;
      clear_end_r  <= 1'b0;
`ifdef GOBANG_CLEAR_SWEEP_EN
      sweep_cnt_r  <= 9'd0;
`endif
    end else begin
      state_r     <= state_nx_s;
      busy_r      <= (state_nx_s != IDLE);
      // Pulsed outputs fall back to their idle level unless a state drives them.
      ack_r       <= 2'b00;
      mem_we_r    <= 1'b0;
      mem_rst_n_r <= 1'b1;
      // A player re-arms whenever its request line is seen low.
      armed_r     <= armed_r | ~bus.req;

      case (state_r)
        IDLE: begin
          if (bus.clear) begin
            clear_end_r <= 1'b0;
`ifdef GOBANG_CLEAR_SWEEP_EN
            sweep_cnt_r <= 9'd0;
`else
            mem_rst_n_r <= 1'b0;
`endif
          end else if (start_move_s) begin
            player_r         <= turn_r;
            xy_r             <= turn_r ? bus.req_xy1 : bus.req_xy0;
            armed_r[turn_r]  <= 1'b0;
          end else begin
            player_r <= player_r;
          end
        end
        CHECK: begin
          if (cell_empty_s) begin
            mem_we_r     <= 1'b1;
            mem_select_r <= xy_r;
            mem_data_r   <= {1'b0, player_r} + 2'b01;
          end else begin
            ack_r      <= player_onehot(player_r);
            accepted_r <= 1'b0;
          end
        end
        WRITE: begin
          ack_r      <= player_onehot(player_r);
          accepted_r <= 1'b1;
        end
        ACK: begin
          if (accepted_r) begin
            turn_r <= ~turn_r;
            if (move_count_r != 9'd256) begin
              move_count_r <= move_count_r + 9'd1;
            end else begin
              move_count_r <= move_count_r;
            end
          end else begin
            turn_r <= turn_r;
          end
        end
        CLEAR: begin
          if (clear_end_r) begin
            clear_end_r  <= 1'b0;
            turn_r       <= 1'b0;
            move_count_r <= 9'd0;
            armed_r      <= 2'b11;
`ifdef GOBANG_CLEAR_SWEEP_EN
          end else if (sweep_cnt_r == 9'd256) begin
            // Last write has been presented; hold one cycle before completing.
            clear_end_r <= 1'b1;
          end else begin
            mem_we_r     <= 1'b1;
            mem_select_r <= sweep_cnt_r[7:0];
            mem_data_r   <= 2'b00;
            sweep_cnt_r  <= sweep_cnt_r + 9'd1;
          end
`else
          end else begin
            // mem_rst_n was low for this single cycle; finish on the next.
            clear_end_r <= 1'b1;
          end
`endif
        end
        default: begin
          clear_end_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_select = mem_select_r;
  assign bus.mem_data   = mem_data_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_rst_n  = mem_rst_n_r;
  assign bus.ack        = ack_r;
  assign bus.accepted   = accepted_r;
  assign bus.turn       = turn_r;
  assign bus.busy       = busy_r;
  assign bus.move_count = move_count_r;

endmodule

// File: tb/tb_gobang_move_ctrl.sv
// tb_gobang_move_ctrl
//
// Directed bench for gobang_move_ctrl. It models the board memory, which
// shows a write on the cycle after mem_we and is cleared by mem_rst_n. It
// applies a table of move vectors, then hand-written sequences for a held
// request, the clear and a reset that aborts a clear. It follows
// GOBANG_CLEAR_SWEEP_EN to pick the clear expectations.
`timescale 1ns/1ps
module tb_gobang_move_ctrl;
  logic clock;
  logic reset;
  logic mem_init;
  logic [511:0] board_m;

  gobang_move_ctrl_if bus ();

  gobang_move_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Board memory model: a write becomes visible on the cycle after mem_we.
  always @(posedge clock) begin
    if (mem_init || !bus.mem_rst_n) board_m <= '0;
    else if (bus.mem_we) board_m[{bus.mem_select, 1'b0} +: 2] <= bus.mem_data;
  end
  assign bus.board = board_m;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Observations gathered over a six-cycle window after a request is applied.
  int ack_pulses, ack_at, we_n, we_at;
  logic [1:0] ack_seen, data_seen;
  logic acc_seen;
  logic [7:0] sel_seen;

  task automatic window();
    ack_pulses = 0; ack_at = 0; we_n = 0; we_at = 0;
    ack_seen = 2'b00; data_seen = 2'b00; acc_seen = 1'b0; sel_seen = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.ack != 2'b00) begin
        ack_pulses++; ack_seen = bus.ack; ack_at = i; acc_seen = bus.accepted;
      end
      if (bus.mem_we) begin
        we_n++; we_at = i; sel_seen = bus.mem_select; data_seen = bus.mem_data;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"},   bus.mem_select, 8'h00);
    check({tag, "_data"},  bus.mem_data,   2'b00);
    check({tag, "_we"},    bus.mem_we,     1'b0);
    check({tag, "_rstn"},  bus.mem_rst_n,  1'b1);
    check({tag, "_ack"},   bus.ack,        2'b00);
    check({tag, "_acc"},   bus.accepted,   1'b0);
    check({tag, "_turn"},  bus.turn,       1'b0);
    check({tag, "_busy"},  bus.busy,       1'b0);
    check({tag, "_count"}, bus.move_count, 9'd0);
  endtask

  // Check an accepted move seen in the last window.
  task automatic check_accept(input string tag, input logic [1:0] exp_ack, input logic [7:0] exp_sel,
                              input logic exp_turn, input logic [8:0] exp_cnt);
    check({tag, "_ack"},    ack_seen, exp_ack);
    check({tag, "_ackn"},   ack_pulses, 1);
    check({tag, "_ackat"},  ack_at, 3);
    check({tag, "_acc"},    acc_seen, 1'b1);
    check({tag, "_wen"},    we_n, 1);
    check({tag, "_weat"},   we_at, 2);
    check({tag, "_sel"},    sel_seen, exp_sel);
    check({tag, "_data"},   data_seen, exp_ack);
    check({tag, "_turn"},   bus.turn, exp_turn);
    check({tag, "_count"},  bus.move_count, exp_cnt);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] xy0;
    logic [7:0] xy1;
    logic [1:0] ack;    // expected ack pattern, 00 = none
    logic       acc;
    int         ack_at; // window sample holding the ack
    int         we_n;   // expected mem_we cycles
    logic [7:0] sel;
    logic [1:0] data;
    logic       turn;   // after the move
    logic [8:0] cnt;
  } vec_t;

  vec_t vecs[7];
  int exp_pulses;
  int busy_n, we_cnt, order_bad, data_bad, rstn_low, ack_n, exp_addr;
  logic done, hit;

  initial begin
    vecs[0] = '{2'b01, 8'h37, 8'h00, 2'b01, 1'b1, 3, 1, 8'h37, 2'b01, 1'b1, 9'd1};
    vecs[1] = '{2'b11, 8'h00, 8'h37, 2'b10, 1'b0, 2, 0, 8'h00, 2'b00, 1'b1, 9'd1};
    vecs[2] = '{2'b01, 8'h12, 8'h00, 2'b00, 1'b0, 0, 0, 8'h00, 2'b00, 1'b1, 9'd1};
    vecs[3] = '{2'b10, 8'h00, 8'h00, 2'b10, 1'b1, 3, 1, 8'h00, 2'b10, 1'b0, 9'd2};
    vecs[4] = '{2'b01, 8'hFF, 8'h00, 2'b01, 1'b1, 3, 1, 8'hFF, 2'b01, 1'b1, 9'd3};
    vecs[5] = '{2'b10, 8'h00, 8'hFF, 2'b10, 1'b0, 2, 0, 8'h00, 2'b00, 1'b1, 9'd3};
    vecs[6] = '{2'b10, 8'h00, 8'h80, 2'b10, 1'b1, 3, 1, 8'h80, 2'b10, 1'b0, 9'd4};

    reset = 1'b0; mem_init = 1'b1;
    bus.req = 2'b00; bus.req_xy0 = 8'h00; bus.req_xy1 = 8'h00; bus.clear = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("rst");
    mem_init = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Table-driven move vectors.
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      bus.req = vecs[k].req; bus.req_xy0 = vecs[k].xy0; bus.req_xy1 = vecs[k].xy1;
      window();
      bus.req = 2'b00;
      exp_pulses = (vecs[k].ack != 2'b00) ? 1 : 0;
      check($sformatf("v%0d_ackn", k), ack_pulses, exp_pulses);
      check($sformatf("v%0d_ack", k), ack_seen, vecs[k].ack);
      if (vecs[k].ack != 2'b00) begin
        check($sformatf("v%0d_ackat", k), ack_at, vecs[k].ack_at);
        check($sformatf("v%0d_acc", k), acc_seen, vecs[k].acc);
      end
      check($sformatf("v%0d_wen", k), we_n, vecs[k].we_n);
      if (vecs[k].we_n != 0) begin
        check($sformatf("v%0d_weat", k), we_at, 2);
        check($sformatf("v%0d_sel", k), sel_seen, vecs[k].sel);
        check($sformatf("v%0d_data", k), data_seen, vecs[k].data);
      end
      check($sformatf("v%0d_turn", k), bus.turn, vecs[k].turn);
      check($sformatf("v%0d_count", k), bus.move_count, vecs[k].cnt);
      repeat (2) @(negedge clock);
    end

    // Held req[0]: one move only; re-armed after one low cycle.
    @(negedge clock);
    bus.req = 2'b01; bus.req_xy0 = 8'h44;
    window();
    check_accept("hold1", 2'b01, 8'h44, 1'b1, 9'd5);
    bus.req = 2'b11; bus.req_xy1 = 8'h45;
    window();
    check_accept("hold2", 2'b10, 8'h45, 1'b0, 9'd6);
    bus.req = 2'b01;
    window();
    check("hold3_ackn", ack_pulses, 0);
    check("hold3_wen", we_n, 0);
    check("hold3_turn", bus.turn, 1'b0);
    bus.req = 2'b00;
    @(negedge clock);
    bus.req = 2'b01; bus.req_xy0 = 8'h46;
    window();
    check_accept("hold4", 2'b01, 8'h46, 1'b1, 9'd7);
    bus.req = 2'b00;
    repeat (2) @(negedge clock);

    // Clear, raised together with a player 1 request: clear has priority.
    @(negedge clock);
    bus.clear = 1'b1; bus.req = 2'b10; bus.req_xy1 = 8'h50;
    busy_n = 0; we_cnt = 0; order_bad = 0; data_bad = 0; rstn_low = 0; ack_n = 0; exp_addr = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clock);
      @(negedge clock);
      bus.clear = 1'b0; bus.req = 2'b00;
      if (bus.mem_we) begin
        if (bus.mem_select !== exp_addr[7:0]) order_bad++;
        if (bus.mem_data !== 2'b00) data_bad++;
        exp_addr++; we_cnt++;
      end
      if (!bus.mem_rst_n) rstn_low++;
      if (bus.ack != 2'b00) ack_n++;
      if (bus.busy) busy_n++;
      else done = 1'b1;
    end
    check("clr_done", done, 1'b1);
`ifdef GOBANG_CLEAR_SWEEP_EN
    check("clr_busy", busy_n, 258);
    check("clr_wen", we_cnt, 256);
    check("clr_rstn", rstn_low, 0);
`else
    check("clr_busy", busy_n, 2);
    check("clr_wen", we_cnt, 0);
    check("clr_rstn", rstn_low, 1);
`endif
    check("clr_order", order_bad, 0);
    check("clr_data", data_bad, 0);
    check("clr_ackn", ack_n, 0);
    check("clr_turn", bus.turn, 1'b0);
    check("clr_count", bus.move_count, 9'd0);
    check("clr_board", (board_m == '0), 1'b1);

    // A move so turn/count are non-zero before the reset abort.
    repeat (2) @(negedge clock);
    bus.req = 2'b01; bus.req_xy0 = 8'h10;
    window();
    check_accept("pre", 2'b01, 8'h10, 1'b1, 9'd1);
    bus.req = 2'b00;
    repeat (2) @(negedge clock);

    // Reset in the middle of a clear.
    bus.clear = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clock);
      @(negedge clock);
      bus.clear = 1'b0;
`ifdef GOBANG_CLEAR_SWEEP_EN
      if (bus.mem_we && bus.mem_select == 8'h80) hit = 1'b1;
`else
      if (!bus.mem_rst_n) hit = 1'b1;
`endif
    end
    check("abort_hit", hit, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_idle_busy", bus.busy, 1'b0);
    check("abort_idle_we", bus.mem_we, 1'b0);
    bus.req = 2'b01; bus.req_xy0 = 8'h22;
    window();
    check_accept("post", 2'b01, 8'h22, 1'b1, 9'd1);
    bus.req = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
